// File: rtl/design_unit.sv
// design_unit: registered 4-input logic evaluator, s = (a & b) ^ (c | d).
// Built from discrete 2-input gate cells (and2, or2, xor2, defined below).
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   a..d   - switch inputs (level signals)
//   s      - registered logic result
//   s_chg  - one-cycle pulse on the edge where s takes a new value
//
// Optional build macro: DESIGN_INPUT_SYNC_EN
//   defined   - each input passes a 2-flop synchronizer (3-cycle input-to-s latency)
//   undefined - inputs drive the gate network directly (1-cycle latency)
module design_unit (
   input  logic clk,
   input  logic rst_n,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic s,
   output logic s_chg
);

   localparam int unsigned N_IN = 4;

   logic [N_IN-1:0] in_raw;
   logic [N_IN-1:0] in_eval;
   logic            ab_and;
   logic            cd_or;
   logic            f;

   assign in_raw = {a, b, c, d};

`ifdef DESIGN_INPUT_SYNC_EN
   logic [N_IN-1:0] sync1_q;
   logic [N_IN-1:0] sync2_q;

   // Two-stage synchronizer on every switch input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= in_raw;
         sync2_q <= sync1_q;
      end
   end

   assign in_eval = sync2_q;
`else
   assign in_eval = in_raw;
`endif

   // Gate network: bit 3 = a, bit 2 = b, bit 1 = c, bit 0 = d.
   and2 u_and (.a(in_eval[3]), .b(in_eval[2]), .y(ab_and));
   or2  u_or  (.a(in_eval[1]), .b(in_eval[0]), .y(cd_or));
   xor2 u_xor (.a(ab_and),     .b(cd_or),      .y(f));

   // Output register and change detect against the previous s.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s     <= 1'b0;
         s_chg <= 1'b0;
      end else begin
         s     <= f;
         s_chg <= (f != s);
      end
   end

endmodule

// 2-input AND cell.
module and2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a & b;
endmodule

// 2-input OR cell.
module or2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a | b;
endmodule

// 2-input XOR cell.
module xor2 (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a ^ b;
endmodule

// File: tb/tb_design_unit.sv
// Directed testbench for design_unit; follows the build latency of DESIGN_INPUT_SYNC_EN.
module tb_design_unit;

`ifdef DESIGN_INPUT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic clk;
   logic rst_n;
   logic a, b, c, d;
   logic s, s_chg;

   int checks;
   int errors;

   design_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .c     (c),
      .d     (d),
      .s     (s),
      .s_chg (s_chg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [3:0] v);
      {a, b, c, d} = v;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_in(4'b1111);
      repeat (3) step();
      checks++;
      if (s !== 1'b0) begin
         errors++;
         $display("FAIL reset_s got %b want 0", s);
      end
      checks++;
      if (s_chg !== 1'b0) begin
         errors++;
         $display("FAIL reset_s_chg got %b want 0", s_chg);
      end
      // Release, drive 1100 (f=1), then reset asynchronously mid-cycle.
      set_in(4'b1100);
      rst_n = 1'b1;
      repeat (LAT + 2) step();
      checks++;
      if (s !== 1'b1) begin
         errors++;
         $display("FAIL pre_async_s got %b want 1", s);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (s !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_s got %b want 0", s);
      end
      checks++;
      if (s_chg !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_s_chg got %b want 0", s_chg);
      end
      step();
      checks++;
      if (s !== 1'b0 || s_chg !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold got s=%b chg=%b want 0 0", s, s_chg);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_sweep();
      logic [15:0] tab;
      tab = 16'h1EEE;  // f for abcd = 15..0
      for (int i = 0; i < 16; i++) begin
         set_in(4'(i));
         repeat (5) step();
         checks++;
         if (s !== tab[i]) begin
            errors++;
            $display("FAIL sweep_s abcd=%b got %b want %b", 4'(i), s, tab[i]);
         end
         checks++;
         if (s_chg !== 1'b0) begin
            errors++;
            $display("FAIL sweep_s_chg abcd=%b got %b want 0", 4'(i), s_chg);
         end
      end
   endtask

   task automatic test_change_pulse();
      set_in(4'b0000);
      repeat (6) step();
      set_in(4'b0001);
      for (int i = 0; i < LAT - 1; i++) begin
         step();
         checks++;
         if (s !== 1'b0) begin
            errors++;
            $display("FAIL pulse_early_s cycle=%0d got %b want 0", i, s);
         end
      end
      step();
      checks++;
      if (s !== 1'b1 || s_chg !== 1'b1) begin
         errors++;
         $display("FAIL pulse_rise got s=%b chg=%b want 1 1", s, s_chg);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (s !== 1'b1 || s_chg !== 1'b0) begin
            errors++;
            $display("FAIL pulse_hold cycle=%0d got s=%b chg=%b want 1 0", i, s, s_chg);
         end
      end
      set_in(4'b0011);
      for (int i = 0; i < LAT + 2; i++) begin
         step();
         checks++;
         if (s !== 1'b1 || s_chg !== 1'b0) begin
            errors++;
            $display("FAIL pulse_0011 cycle=%0d got s=%b chg=%b want 1 0", i, s, s_chg);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic exp_s;
      set_in(4'b1100);
      repeat (6) step();
      for (int k = 0; k < 12; k++) begin
         set_in((k % 2 == 0) ? 4'b1110 : 4'b1100);
         step();
         if (k >= LAT - 1) begin
            exp_s = ((k - LAT + 1) % 2 == 0) ? 1'b0 : 1'b1;
            checks++;
            if (s !== exp_s || s_chg !== 1'b1) begin
               errors++;
               $display("FAIL b2b k=%0d got s=%b chg=%b want %b 1", k, s, s_chg, exp_s);
            end
         end
      end
   endtask

   task automatic test_latency();
      int n;
      set_in(4'b0000);
      repeat (6) step();
      set_in(4'b1000);
      step();
      set_in(4'b1001);
      n = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (s === 1'b1) begin
            n = i;
            break;
         end
      end
      checks++;
      if (n != LAT) begin
         errors++;
         $display("FAIL latency got %0d cycles want %0d (0 = timeout)", n, LAT);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      set_in(4'b0000);
      #2;
      test_reset();
      test_sweep();
      test_change_pulse();
      test_back_to_back();
      test_latency();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
